lsu_unaligned: RTL

Parametrised load/store unit for the vanilla core that sits between EXE and the local DMEM / network TX. It classifies each effective address as local-DMEM or remote and performs aligned local accesses. It splits misaligned local halfword/word accesses into two aligned DMEM accesses, merging load data or rotating store data and masks. Remote requests are buffered in a small FIFO toward network TX with valid/ready backpressure.

---
 rtl/lsu_unaligned.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_unaligned.sv
// Load/store unit between EXE and local DMEM / network TX. Classifies addresses as local or remote,
// splits misaligned local accesses into two aligned DMEM accesses and queues remote requests.

module lsu_unaligned #(
    parameter int          data_width_p      = 32,
    parameter int          dmem_size_p       = 1024,
    parameter int          low_spm_bytes_p   = 256,
    parameter logic [31:0] high_spm_base_p   = 32'h0003_F100,
    parameter int          remote_fifo_els_p = 2,
    parameter int          x_cord_width_p    = 6,
    parameter int          y_cord_width_p    = 5,
    localparam int dmem_addr_width_lp = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          req_v_i,
    output logic                          req_ready_o,
    input  logic                          req_w_i,
    input  logic [1:0]                    req_size_i,
    input  logic                          req_unsigned_i,
    input  logic [data_width_p-1:0]       req_addr_i,
    input  logic [data_width_p-1:0]       req_data_i,
    input  logic [4:0]                    req_rd_i,
    input  logic [x_cord_width_p-1:0]     tg_x_cord_i,
    input  logic [y_cord_width_p-1:0]     tg_y_cord_i,
    output logic                          dmem_v_o,
    output logic                          dmem_w_o,
    output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
    output logic [data_width_p-1:0]       dmem_data_o,
    output logic [3:0]                    dmem_mask_o,
    input  logic [data_width_p-1:0]       dmem_data_i,
    output logic                          wb_v_o,
    output logic [4:0]                    wb_rd_o,
    output logic [data_width_p-1:0]       wb_data_o,
    output logic                          remote_v_o,
    input  logic                          remote_ready_i,
    output logic                          remote_w_o,
    output logic [31:0]                   remote_addr_o,
    output logic [31:0]                   remote_data_o,
    output logic [3:0]                    remote_mask_o,
    output logic [4:0]                    remote_rd_o,
    output logic [1:0]                    remote_size_o,
    output logic                          remote_unsigned_o,
    output logic                          misaligned_err_o
);

    localparam int tg_addr_width_lp = 32 - 3 - x_cord_width_p - y_cord_width_p;
    localparam logic [31:0] low_limit_lp     = 32'(low_spm_bytes_p);
    localparam logic [31:0] tg_high_limit_lp = 32'(65536 - (4 * dmem_size_p - low_spm_bytes_p));
    localparam logic [31:0] high_spm_top_lp  = 32'h0003_FFFF;
    localparam logic [dmem_addr_width_lp-1:0] last_idx_lp = dmem_addr_width_lp'(dmem_size_p - 1);
    localparam int ptr_width_lp = $clog2(remote_fifo_els_p);
    localparam int cnt_width_lp = $clog2(remote_fifo_els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(remote_fifo_els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(remote_fifo_els_p);

    typedef struct packed {
        logic [2:0]                  remote;
        logic [y_cord_width_p-1:0]   y_cord;
        logic [x_cord_width_p-1:0]   x_cord;
        logic [tg_addr_width_lp-1:0] addr;
    } tile_group_addr_s;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        uns;
    } remote_req_s;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        WB     = 3'd3,
        ENQ    = 3'd4
    } state_e;

    function automatic logic is_local_addr(input logic [31:0] addr,
                                           input logic [x_cord_width_p-1:0] x,
                                           input logic [y_cord_width_p-1:0] y);
        tile_group_addr_s tg;
        logic [31:0]      field;
        tg    = addr;
        field = 32'(tg.addr);
        return (addr < low_limit_lp)
            || ((addr >= high_spm_base_p) && (addr <= high_spm_top_lp))
            || ((tg.remote == 3'b001) && (tg.x_cord == x) && (tg.y_cord == y)
                && ((field < low_limit_lp) || (field >= tg_high_limit_lp)));
    endfunction

    state_e                        state_r;
    logic [31:0]                   addr_r;
    logic                          w_r;
    logic [1:0]                    size_r;
    logic                          unsigned_r;
    logic [4:0]                    rd_r;
    logic [31:0]                   store_data_r;
    logic [6:0]                    mask_r;
    logic [dmem_addr_width_lp-1:0] idx_r;
    logic                          misaligned_r;
    logic [31:0]                   first_word_r;

    logic [1:0]                    off_s;
    logic                          misaligned_s;
    logic [31:0]                   repl_s;
    logic [31:0]                   rot_s;
    logic [6:0]                    base_mask_s;
    logic [6:0]                    m7_s;
    logic [dmem_addr_width_lp-1:0] idx_s;
    logic                          local_s;
    logic [dmem_addr_width_lp-1:0] next_idx_s;
    logic [31:0]                   lo_s;
    logic [31:0]                   merged_s;
    logic [31:0]                   ext_s;

    remote_req_s                   fifo_mem_r [remote_fifo_els_p];
    logic [ptr_width_lp-1:0]       rd_ptr_r;
    logic [ptr_width_lp-1:0]       wr_ptr_r;
    logic [cnt_width_lp-1:0]       cnt_r;
    logic                          fifo_full_s;
    logic                          enq_s;
    logic                          deq_s;
    remote_req_s                   enq_entry_s;
    remote_req_s                   head_s;

    assign off_s      = req_addr_i[1:0];
    assign idx_s      = req_addr_i[2 +: dmem_addr_width_lp];
    assign local_s    = is_local_addr(req_addr_i, tg_x_cord_i, tg_y_cord_i);
    assign m7_s       = base_mask_s << off_s;
    assign next_idx_s = (idx_r == last_idx_lp) ? '0 : idx_r + 1'b1;

    // Decode the incoming request: size mask, misalignment, replicated and rotated store data.
    always_comb begin
        misaligned_s = 1'b0;
        repl_s       = req_data_i;
        base_mask_s  = 7'b000_1111;
        case (req_size_i)
            2'd0: begin
                repl_s      = {4{req_data_i[7:0]}};
                base_mask_s = 7'b000_0001;
            end
            2'd1: begin
                repl_s       = {2{req_data_i[15:0]}};
                base_mask_s  = 7'b000_0011;
                misaligned_s = (off_s == 2'd3);
            end
            default: misaligned_s = (off_s != 2'd0);
        endcase
        case (off_s)
            2'd1:    rot_s = {repl_s[23:0], repl_s[31:24]};
            2'd2:    rot_s = {repl_s[15:0], repl_s[31:16]};
            2'd3:    rot_s = {repl_s[7:0],  repl_s[31:8]};
            default: rot_s = repl_s;
        endcase
    end

    // Merge the two read words, then size-trim and extend for writeback.
    always_comb begin
        lo_s = misaligned_r ? first_word_r : dmem_data_i;
        case (addr_r[1:0])
            2'd1:    merged_s = {dmem_data_i[7:0],  lo_s[31:8]};
            2'd2:    merged_s = {dmem_data_i[15:0], lo_s[31:16]};
            2'd3:    merged_s = {dmem_data_i[23:0], lo_s[31:24]};
            default: merged_s = lo_s;
        endcase
        case (size_r)
            2'd0:    ext_s = unsigned_r ? {24'd0, merged_s[7:0]}  : {{24{merged_s[7]}},  merged_s[7:0]};
            2'd1:    ext_s = unsigned_r ? {16'd0, merged_s[15:0]} : {{16{merged_s[15]}}, merged_s[15:0]};
            default: ext_s = merged_s;
        endcase
    end

    assign wb_data_o = wb_v_o ? ext_s : '0;

    // Request FSM; every output is registered alongside the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r          <= IDLE;
            req_ready_o      <= 1'b1;
            dmem_v_o         <= 1'b0;
            dmem_w_o         <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_data_o      <= '0;
            dmem_mask_o      <= 4'h0;
            wb_v_o           <= 1'b0;
            wb_rd_o          <= 5'd0;
            misaligned_err_o <= 1'b0;
            addr_r           <= 32'd0;
            w_r              <= 1'b0;
            size_r           <= 2'd0;
            unsigned_r       <= 1'b0;
            rd_r             <= 5'd0;
            store_data_r     <= 32'd0;
            mask_r           <= 7'd0;
            idx_r            <= '0;
            misaligned_r     <= 1'b0;
            first_word_r     <= 32'd0;
        end else begin
            dmem_v_o         <= 1'b0;
            dmem_w_o         <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_data_o      <= '0;
            dmem_mask_o      <= 4'h0;
            wb_v_o           <= 1'b0;
            wb_rd_o          <= 5'd0;
            misaligned_err_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_v_i) begin
                        addr_r       <= req_addr_i;
                        w_r          <= req_w_i;
                        size_r       <= req_size_i;
                        unsigned_r   <= req_unsigned_i;
                        rd_r         <= req_rd_i;
                        store_data_r <= local_s ? rot_s : repl_s;
                        mask_r       <= m7_s;
                        idx_r        <= idx_s;
                        misaligned_r <= misaligned_s;
                        req_ready_o  <= 1'b0;
                        if (local_s) begin
                            state_r     <= ISSUE0;
                            dmem_v_o    <= 1'b1;
                            dmem_w_o    <= req_w_i;
                            dmem_addr_o <= idx_s;
                            dmem_data_o <= req_w_i ? rot_s : 32'd0;
                            dmem_mask_o <= m7_s[3:0];
                        end else begin
                            state_r <= ENQ;
                        end
                    end
                end
                ISSUE0: begin
                    if (misaligned_r) begin
                        state_r     <= ISSUE1;
                        dmem_v_o    <= 1'b1;
                        dmem_w_o    <= w_r;
                        dmem_addr_o <= next_idx_s;
                        dmem_data_o <= w_r ? store_data_r : 32'd0;
                        dmem_mask_o <= {1'b0, mask_r[6:4]};
                    end else if (!w_r) begin
                        state_r <= WB;
                        wb_v_o  <= 1'b1;
                        wb_rd_o <= rd_r;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_o <= 1'b1;
                    end
                end
                ISSUE1: begin
                    first_word_r <= dmem_data_i;
                    if (!w_r) begin
                        state_r <= WB;
                        wb_v_o  <= 1'b1;
                        wb_rd_o <= rd_r;
                    end else begin
                        state_r     <= IDLE;
                        req_ready_o <= 1'b1;
                    end
                end
                WB: begin
                    state_r     <= IDLE;
                    req_ready_o <= 1'b1;
                end
                ENQ: begin
                    // A misaligned remote request is reported and dropped, never queued.
                    if (misaligned_r) begin
                        misaligned_err_o <= 1'b1;
                        state_r          <= IDLE;
                        req_ready_o      <= 1'b1;
                    end else if (!fifo_full_s) begin
                        state_r     <= IDLE;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_full_s = (cnt_r == full_cnt_lp);
    assign enq_s       = (state_r == ENQ) && !misaligned_r && !fifo_full_s;
    assign deq_s       = remote_v_o && remote_ready_i;
    assign enq_entry_s = '{w: w_r, addr: addr_r, data: store_data_r, mask: mask_r[3:0],
                           rd: rd_r, size: size_r, uns: unsigned_r};
    assign head_s      = fifo_mem_r[rd_ptr_r];

    assign remote_v_o        = (cnt_r != '0);
    assign remote_w_o        = remote_v_o ? head_s.w    : 1'b0;
    assign remote_addr_o     = remote_v_o ? head_s.addr : 32'd0;
    assign remote_data_o     = remote_v_o ? head_s.data : 32'd0;
    assign remote_mask_o     = remote_v_o ? head_s.mask : 4'h0;
    assign remote_rd_o       = remote_v_o ? head_s.rd   : 5'd0;
    assign remote_size_o     = remote_v_o ? head_s.size : 2'd0;
    assign remote_unsigned_o = remote_v_o ? head_s.uns  : 1'b0;

    // Remote request FIFO; enqueue is blocked while full so a full enq+deq never occurs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < remote_fifo_els_p; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else begin
            if (enq_s) begin
                fifo_mem_r[wr_ptr_r] <= enq_entry_s;
                wr_ptr_r             <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
            end
            if (deq_s) begin
                rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
            end
            case ({enq_s, deq_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule
